// File: rtl/mode_select_fsm_if.sv
// mode_select_fsm_if: button inputs and mode outputs of the mode selector
interface mode_select_fsm_if #(
  parameter int NUM_MODES = 5,
  parameter int MODE_W = $clog2(NUM_MODES)
);
  logic pushed_next;
  logic pushed_prev;
  logic lock;
  logic [MODE_W-1:0] mode;
  logic [NUM_MODES-1:0] mode_onehot;
  logic mode_changed;
  modport master (output pushed_next, pushed_prev, lock, input mode, mode_onehot, mode_changed);
  modport slave (input pushed_next, pushed_prev, lock, output mode, mode_onehot, mode_changed);
endinterface

// File: rtl/mode_select_fsm.sv
// mode_select_fsm: two-button debounced mode stepper with wrap/saturate, lock and change strobe
module mode_select_fsm #(
  parameter int NUM_MODES = 5,
  parameter int MODE_W = $clog2(NUM_MODES),
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WRAP = 1,
  parameter int RESET_MODE = 0
) (
  input logic clk,
  input logic n_rst,
  mode_select_fsm_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [MODE_W-1:0] TOP = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] RST = MODE_W'(RESET_MODE);
  localparam logic [NUM_MODES-1:0] ONE = NUM_MODES'(1);
  typedef enum logic [1:0] {EV_NONE, EV_NEXT, EV_PREV} ev_e;
  logic [1:0] raw, press;
  assign raw = {bus.pushed_prev, bus.pushed_next};
  // bit 0 is next, bit 1 is prev; each gets its own synchroniser and debouncer
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic s1, s, d, d_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) {s1, s, d, d_q, cnt} <= '0;
      else begin
        s1 <= raw[b];
        s <= s1;
        d_q <= d;
        if (s == d) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          d <= s;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    assign press[b] = d & ~d_q;
  end
  ev_e ev;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [NUM_MODES-1:0] onehot_q;
  logic changed_q;
  // simultaneous or locked events are swallowed rather than deferred
  always_comb begin
    ev = (bus.lock || press[0] == press[1]) ? EV_NONE : (press[0] ? EV_NEXT : EV_PREV);
    mode_d = ev == EV_NEXT ? (mode_q == TOP ? (WRAP != 0 ? '0 : TOP) : mode_q + 1'b1) :
             ev == EV_PREV ? (mode_q == '0 ? (WRAP != 0 ? TOP : '0) : mode_q - 1'b1) :
             mode_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      mode_q <= RST;
      onehot_q <= ONE << RST;
      changed_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      onehot_q <= ONE << mode_d;
      changed_q <= mode_d != mode_q;
    end
  assign bus.mode = mode_q;
  assign bus.mode_onehot = onehot_q;
  assign bus.mode_changed = changed_q;
endmodule
